// File: rtl/lut_neuron_if.sv
// lut_neuron_if: handshake bundle for the programmable LUT neuron.
//   cfg_*     : table-load stream (start pulse, valid/ready, one word per beat)
//   in_*      : lookup request stream (valid/ready, address)
//   out_*     : lookup result stream (valid/ready, table word)
//   loaded    : table fully written and serving lookups
// The master modport drives requests and config; the slave modport is the neuron.
interface lut_neuron_if #(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 1
);
  logic                cfg_start;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [OUT_BITS-1:0] cfg_data;
  logic                in_valid;
  logic                in_ready;
  logic [IN_BITS-1:0]  in_data;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_BITS-1:0] out_data;
  logic                loaded;

  modport master (
    output cfg_start, cfg_valid, cfg_data, in_valid, in_data, out_ready,
    input  cfg_ready, in_ready, out_valid, out_data, loaded
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data, in_valid, in_data, out_ready,
    output cfg_ready, in_ready, out_valid, out_data, loaded
  );
endinterface

// File: rtl/lut_neuron_prog.sv
// lut_neuron_prog: runtime-programmable LUT neuron.
// A 2**IN_BITS x OUT_BITS table is streamed in over the cfg port (ascending
// index order, restartable with cfg_start) and then serves lookups through a
// one-stage registered valid/ready pipeline.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : lut_neuron_if slave modport (cfg_*, in_*, out_*, loaded)
module lut_neuron_prog #(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 1
) (
  input logic         clk,
  input logic         rst,
  lut_neuron_if.slave bus
);

  localparam int DEPTH = 2 ** IN_BITS;
  localparam logic [IN_BITS-1:0] LAST_IDX = IN_BITS'(DEPTH - 1);
  localparam logic [IN_BITS-1:0] IDX_ONE  = IN_BITS'(1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t              state;
  logic [IN_BITS-1:0]  wr_ptr;
  logic [OUT_BITS-1:0] lut_mem [DEPTH];
  logic                out_valid_q;
  logic [OUT_BITS-1:0] out_data_q;
  logic                loaded_q;

  logic cfg_fire;
  logic in_fire;
  logic wr_en;

  // Readies come only from registered state; in_ready also looks at
  // out_ready so a held result can be replaced in the same cycle it leaves.
  assign bus.cfg_ready = (state == LOAD);
  assign bus.in_ready  = (state == RUN) && (!out_valid_q || bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.loaded    = loaded_q;

  assign cfg_fire = bus.cfg_valid && bus.cfg_ready;
  assign in_fire  = bus.in_valid && bus.in_ready;
  // A restart pulse wins over a word offered in the same cycle.
  assign wr_en    = cfg_fire && !bus.cfg_start;

  // Table storage has no reset: it is only read in RUN, which is reachable
  // only after a complete load.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      lut_mem[wr_ptr] <= bus.cfg_data;
    end
  end

  // Load sequencing: EMPTY waits for a start pulse, LOAD counts words in,
  // RUN serves lookups until the next start pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      wr_ptr   <= '0;
      loaded_q <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (bus.cfg_start) begin
            state  <= LOAD;
            wr_ptr <= '0;
          end
        end
        LOAD: begin
          if (bus.cfg_start) begin
            wr_ptr <= '0;
          end else if (cfg_fire) begin
            wr_ptr <= wr_ptr + IDX_ONE;
            if (wr_ptr == LAST_IDX) begin
              state    <= RUN;
              loaded_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.cfg_start) begin
            state    <= LOAD;
            wr_ptr   <= '0;
            loaded_q <= 1'b0;
          end
        end
        default: begin
          state    <= EMPTY;
          wr_ptr   <= '0;
          loaded_q <= 1'b0;
        end
      endcase
    end
  end

  // Output register: a result stays put until accepted, even across a
  // reload, so it always carries the table value at the time of lookup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (in_fire) begin
      out_valid_q <= 1'b1;
      out_data_q  <= lut_mem[bus.in_data];
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lut_neuron_prog.sv
// tb_lut_neuron_prog: randomized self-checking bench for lut_neuron_prog.
// A behavioural model (mode, word count, shadow table, pending flag) predicts
// readies and status each cycle; accepted lookups push their expected word
// into a scoreboard queue that a separate monitor drains on output beats.
module tb_lut_neuron_prog;

  localparam int IN_BITS  = 6;
  localparam int OUT_BITS = 1;
  localparam int DEPTH    = 2 ** IN_BITS;

  localparam int M_EMPTY = 0;
  localparam int M_LOAD  = 1;
  localparam int M_RUN   = 2;

  logic clk;
  logic rst;

  lut_neuron_if #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) bus ();

  lut_neuron_prog #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state
  int                  mode    = M_EMPTY;
  int                  count   = 0;
  logic                pending = 1'b0;
  logic [OUT_BITS-1:0] ref_table [DEPTH];
  logic [OUT_BITS-1:0] sb [$];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Scoreboard monitor: every presented result must match the oldest
  // outstanding expectation; it is retired when accepted.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (sb.size() == 0) begin
        check_output("unexpected_out", 32'd1, 32'd0);
      end else begin
        check_output("out_data", 32'(bus.out_data), 32'(sb[0]));
        if (bus.out_ready) void'(sb.pop_front());
      end
    end
  end

  // One clock of stimulus: drive, check predicted status mid-cycle, then
  // advance the model across the rising edge.
  task automatic apply_stimulus(input logic cs, input logic cv, input logic [OUT_BITS-1:0] cd,
                                input logic iv, input logic [IN_BITS-1:0] id, input logic ordy);
    logic exp_in_ready;
    logic in_hs;
    logic cfg_hs;
    bus.cfg_start = cs;
    bus.cfg_valid = cv;
    bus.cfg_data  = cd;
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    @(negedge clk);
    exp_in_ready = (mode == M_RUN) && (!pending || ordy);
    check_output("cfg_ready", 32'(bus.cfg_ready), 32'(mode == M_LOAD));
    check_output("in_ready",  32'(bus.in_ready),  32'(exp_in_ready));
    check_output("out_valid", 32'(bus.out_valid), 32'(pending));
    check_output("loaded",    32'(bus.loaded),    32'(mode == M_RUN));
    in_hs  = iv && exp_in_ready;
    cfg_hs = cv && (mode == M_LOAD);
    @(posedge clk);
    #1;
    if (in_hs) begin
      sb.push_back(ref_table[id]);
      pending = 1'b1;
    end else if (ordy) begin
      pending = 1'b0;
    end
    case (mode)
      M_EMPTY: if (cs) begin mode = M_LOAD; count = 0; end
      M_LOAD: begin
        if (cs) count = 0;
        else if (cfg_hs) begin
          ref_table[count] = cd;
          count++;
          if (count == DEPTH) begin mode = M_RUN; count = 0; end
        end
      end
      default: if (cs) begin mode = M_LOAD; count = 0; end
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("rst_loaded",    32'(bus.loaded),    32'd0);
    check_output("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check_output("rst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
    mode = M_EMPTY;
    count = 0;
    pending = 1'b0;
    sb.delete();
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [OUT_BITS-1:0] pattern_word(input int idx);
    logic [IN_BITS-1:0] i;
    i = IN_BITS'(idx);
    return OUT_BITS'(i[0] ^ i[5]);
  endfunction

  function automatic logic [IN_BITS-1:0] rnd_addr();
    return IN_BITS'($urandom_range(0, DEPTH - 1));
  endfunction

  // Stream a full table; cfg_valid is randomly withheld when stall is set.
  task automatic load_table(input bit use_pattern, input bit stall);
    int guard;
    apply_stimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    guard = 0;
    while (mode == M_LOAD && guard < 1000) begin
      apply_stimulus(1'b0, stall ? 1'($urandom_range(0, 1)) : 1'b1,
                     use_pattern ? pattern_word(count) : OUT_BITS'($urandom),
                     1'b1, rnd_addr(), 1'b1);
      guard++;
    end
    check_output("load_done", 32'(mode == M_RUN), 32'd1);
  endtask

  initial begin
    logic [IN_BITS-1:0] probe [4];
    int guard;
    rst = 1'b1;
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Empty table: lookups must be refused.
    repeat (10) apply_stimulus(1'b0, 1'b0, '0, 1'b1, rnd_addr(), 1'b1);

    // Pattern table and the four documented probes.
    load_table(1'b1, 1'b0);
    probe[0] = 6'h01; probe[1] = 6'h21; probe[2] = 6'h20; probe[3] = 6'h00;
    for (int k = 0; k < 4; k++) apply_stimulus(1'b0, 1'b0, '0, 1'b1, probe[k], 1'b1);
    apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);

    // Back-to-back sweep of every entry.
    for (int a = 0; a < DEPTH; a++) apply_stimulus(1'b0, 1'b0, '0, 1'b1, IN_BITS'(a), 1'b1);
    apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);

    // Output stall with a result pending, then release.
    apply_stimulus(1'b0, 1'b0, '0, 1'b1, 6'h21, 1'b1);
    repeat (5) apply_stimulus(1'b0, 1'b0, '0, 1'b1, rnd_addr(), 1'b0);
    apply_stimulus(1'b0, 1'b0, '0, 1'b1, 6'h01, 1'b1);
    apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);

    // Reload while a result is pending, restart after 30 words, stalled cfg.
    apply_stimulus(1'b0, 1'b0, '0, 1'b1, 6'h20, 1'b0);
    apply_stimulus(1'b1, 1'b0, '0, 1'b1, rnd_addr(), 1'b0);
    guard = 0;
    while (count < 30 && guard < 500) begin
      apply_stimulus(1'b0, 1'($urandom_range(0, 1)), OUT_BITS'($urandom), 1'b1, rnd_addr(),
                     1'($urandom_range(0, 1)));
      guard++;
    end
    apply_stimulus(1'b1, 1'b1, OUT_BITS'($urandom), 1'b1, rnd_addr(), 1'b1);
    guard = 0;
    while (mode == M_LOAD && guard < 1000) begin
      apply_stimulus(1'b0, 1'($urandom_range(0, 1)), OUT_BITS'($urandom), 1'b1, rnd_addr(), 1'b1);
      guard++;
    end
    check_output("reload_done", 32'(mode == M_RUN), 32'd1);
    for (int a = 0; a < DEPTH; a++) apply_stimulus(1'b0, 1'b0, '0, 1'b1, IN_BITS'(a), 1'b1);

    // Reset in the middle of a load.
    apply_stimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    repeat (10) apply_stimulus(1'b0, 1'b1, OUT_BITS'($urandom), 1'b0, '0, 1'b1);
    do_reset();
    repeat (3) apply_stimulus(1'b0, 1'b0, '0, 1'b1, rnd_addr(), 1'b1);

    // Reset in RUN with a result held in the output register.
    load_table(1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0, '0, 1'b1, rnd_addr(), 1'b0);
    apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    do_reset();
    repeat (3) apply_stimulus(1'b0, 1'b0, '0, 1'b1, rnd_addr(), 1'b1);

    // Fully random traffic including occasional reloads.
    load_table(1'b0, 1'b1);
    for (int n = 0; n < 800; n++) begin
      apply_stimulus(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)), OUT_BITS'($urandom),
                     1'($urandom_range(0, 1)), rnd_addr(), ($urandom_range(0, 3) != 0));
    end

    // Drain and make sure nothing is left outstanding.
    guard = 0;
    while ((mode == M_LOAD || pending) && guard < 200) begin
      apply_stimulus(1'b0, 1'b1, OUT_BITS'($urandom), 1'b0, '0, 1'b1);
      guard++;
    end
    repeat (2) apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    check_output("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
